// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: serialises instruction fetch and load/store traffic onto one synchronous memory port
module mem_access_ctrl #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [7:0] HALT_OPCODE = 8'hF0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] mem_address,
   output logic       mem_write_enable,
   output logic [7:0] mem_write_data,
   input  logic [7:0] mem_read_data,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [7:0] instr_data,
   output logic [7:0] instr_pc,
   input  logic       branch_valid,
   input  logic [7:0] branch_target,
   input  logic       dreq_valid,
   output logic       dreq_ready,
   input  logic       dreq_write,
   input  logic [7:0] dreq_addr,
   input  logic [7:0] dreq_wdata,
   output logic       drsp_valid,
   output logic [7:0] drsp_data,
   output logic       halted
);
   typedef enum logic [2:0] {IDLE, I_RD, I_CAP, D_ACC, D_CAP, HALTED} state_t;
   state_t state, next_state, ret_state;
   logic [7:0] pc, d_addr, d_wdata;
   logic d_write, ret_halt, accept, capture, consume, halt_hit;
   // a redirect during a data access sends it back to IDLE instead of HALTED
   assign ret_state = (ret_halt && !branch_valid) ? HALTED : IDLE;
   assign dreq_ready = (state == IDLE) || (state == HALTED);
   assign mem_address = (state == D_ACC) ? d_addr : pc;
   assign mem_write_enable = (state == D_ACC) && d_write;
   assign mem_write_data = mem_write_enable ? d_wdata : 8'h00;
   assign drsp_valid = (state == D_CAP);
   assign drsp_data = drsp_valid ? mem_read_data : 8'h00;
   assign halt_hit = capture && (mem_read_data == HALT_OPCODE);
   // next-state selection and per-cycle control strobes
   always_comb begin
      next_state = state;
      accept = 1'b0;
      capture = 1'b0;
      consume = instr_valid && instr_ready;
      case (state)
         IDLE: begin
            accept = dreq_valid;
            next_state = dreq_valid ? D_ACC
                       : (!branch_valid && (!instr_valid || consume)) ? I_RD : IDLE;
         end
         HALTED: begin
            accept = dreq_valid;
            next_state = dreq_valid ? D_ACC : branch_valid ? IDLE : HALTED;
         end
         I_RD: next_state = branch_valid ? IDLE : I_CAP;
         I_CAP: begin
            capture = !branch_valid;
            next_state = (capture && mem_read_data == HALT_OPCODE) ? HALTED : IDLE;
         end
         D_ACC: next_state = d_write ? ret_state : D_CAP;
         D_CAP: next_state = ret_state;
         default: next_state = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= next_state;
   end
   // pc, instruction buffer, latched data request and halt flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
         instr_valid <= 1'b0;
         instr_data <= 8'h00;
         instr_pc <= 8'h00;
         d_addr <= 8'h00;
         d_wdata <= 8'h00;
         d_write <= 1'b0;
         ret_halt <= 1'b0;
         halted <= 1'b0;
      end else begin
         pc <= branch_valid ? branch_target : capture ? pc + 8'd1 : pc;
         instr_valid <= branch_valid ? 1'b0 : capture ? 1'b1 : consume ? 1'b0 : instr_valid;
         if (capture) begin
            instr_data <= mem_read_data;
            instr_pc <= pc;
         end
         if (accept) begin
            d_addr <= dreq_addr;
            d_wdata <= dreq_wdata;
            d_write <= dreq_write;
         end
         ret_halt <= accept ? (state == HALTED) && !branch_valid : branch_valid ? 1'b0 : ret_halt;
         halted <= branch_valid ? 1'b0 : halt_hit ? 1'b1 : halted;
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: cycle-table and directed-sequence checks of mem_access_ctrl against a behavioural memory
module tb_mem_access_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [7:0] mem_address, mem_write_data, mem_read_data, instr_data, instr_pc;
   logic [7:0] branch_target, dreq_addr, dreq_wdata, drsp_data;
   logic mem_write_enable, instr_valid, instr_ready, branch_valid;
   logic dreq_valid, dreq_ready, dreq_write, drsp_valid, halted;
   logic [7:0] mem [256];
   int errors = 0, checks = 0;

   typedef struct {
      logic ir, bv, dv, dw;
      logic [7:0] bt, da, dd;
      logic [7:0] addr, wd, id, ipc, rd;
      logic we, iv, rdy, rv, h;
   } vec_t;
   vec_t vecs[$];

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .mem_address(mem_address), .mem_write_enable(mem_write_enable),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_write(dreq_write),
      .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
      .drsp_valid(drsp_valid), .drsp_data(drsp_data), .halted(halted)
   );

   always #5 clk = ~clk;

   // synchronous memory: address captured on posedge, data one cycle later
   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_address] <= mem_write_data;
      mem_read_data <= mem[mem_address];
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ir, bv, input logic [7:0] bt, input logic dv, dw,
                               input logic [7:0] da, dd, addr, input logic we, input logic [7:0] wd,
                               input logic iv, input logic [7:0] id, ipc, input logic rdy, rv,
                               input logic [7:0] rd, input logic h);
      vec_t v;
      v.ir = ir; v.bv = bv; v.bt = bt; v.dv = dv; v.dw = dw; v.da = da; v.dd = dd;
      v.addr = addr; v.we = we; v.wd = wd; v.iv = iv; v.id = id; v.ipc = ipc;
      v.rdy = rdy; v.rv = rv; v.rd = rd; v.h = h;
      return v;
   endfunction

   task automatic drive(input logic ir, bv, input logic [7:0] bt, input logic dv, dw,
                        input logic [7:0] da, dd);
      instr_ready = ir; branch_valid = bv; branch_target = bt;
      dreq_valid = dv; dreq_write = dw; dreq_addr = da; dreq_wdata = dd;
   endtask

   task automatic wait_iv(input string name);
      for (int i = 0; i < 10 && !instr_valid; i++) begin
         @(negedge clk);
         #1;
      end
      chk({name, "_valid"}, {7'd0, instr_valid}, 8'h01);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h61; mem[8'h01] = 8'h72; mem[8'h02] = 8'h11; mem[8'h03] = 8'hF0;
      mem[8'h10] = 8'h5A; mem[8'h40] = 8'hA1; mem[8'h41] = 8'hB2; mem[8'hFF] = 8'hC3;
      // fetch 61,72,11,F0 then halt
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h00,0,8'h00,0,8'h00,8'h00,1,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h00,0,8'h00,0,8'h00,8'h00,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h00,0,8'h00,0,8'h00,8'h00,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h01,0,8'h00,1,8'h61,8'h00,1,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h01,0,8'h00,0,8'h61,8'h00,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h01,0,8'h00,0,8'h61,8'h00,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h02,0,8'h00,1,8'h72,8'h01,1,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h02,0,8'h00,0,8'h72,8'h01,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h02,0,8'h00,0,8'h72,8'h01,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h03,0,8'h00,1,8'h11,8'h02,1,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h03,0,8'h00,0,8'h11,8'h02,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h03,0,8'h00,0,8'h11,8'h02,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h04,0,8'h00,1,8'hF0,8'h03,1,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h04,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h04,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,1));
      // store AA to 80 then load it back while halted
      vecs.push_back(mk(1,0,8'h00,1,1,8'h80,8'hAA, 8'h04,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h80,1,8'hAA,0,8'hF0,8'h03,0,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,1,0,8'h80,8'h00, 8'h04,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h80,0,8'h00,0,8'hF0,8'h03,0,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h04,0,8'h00,0,8'hF0,8'h03,0,1,8'hAA,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h04,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,1));
      // redirect out of HALTED to 10, then redirect to 40 during I_CAP
      vecs.push_back(mk(1,1,8'h10,0,0,8'h00,8'h00, 8'h04,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,1));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h10,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h10,0,8'h00,0,8'hF0,8'h03,0,0,8'h00,0));
      vecs.push_back(mk(1,1,8'h40,0,0,8'h00,8'h00, 8'h10,0,8'h00,0,8'hF0,8'h03,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h40,0,8'h00,0,8'hF0,8'h03,1,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h40,0,8'h00,0,8'hF0,8'h03,0,0,8'h00,0));
      vecs.push_back(mk(1,0,8'h00,0,0,8'h00,8'h00, 8'h40,0,8'h00,0,8'hF0,8'h03,0,0,8'h00,0));
      // buffer held with instr_ready=0; a load is still served
      vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00, 8'h41,0,8'h00,1,8'hA1,8'h40,1,0,8'h00,0));
      vecs.push_back(mk(0,0,8'h00,1,0,8'h02,8'h00, 8'h41,0,8'h00,1,8'hA1,8'h40,1,0,8'h00,0));
      vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00, 8'h02,0,8'h00,1,8'hA1,8'h40,0,0,8'h00,0));
      vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00, 8'h41,0,8'h00,1,8'hA1,8'h40,0,1,8'h11,0));
      vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00, 8'h41,0,8'h00,1,8'hA1,8'h40,1,0,8'h00,0));
      vecs.push_back(mk(0,0,8'h00,0,0,8'h00,8'h00, 8'h41,0,8'h00,1,8'hA1,8'h40,1,0,8'h00,0));

      drive(1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_iv", {7'd0, instr_valid}, 8'h00);
      chk("rst_addr", mem_address, 8'h00);
      chk("rst_halted", {7'd0, halted}, 8'h00);
      chk("rst_drsp", {7'd0, drsp_valid}, 8'h00);
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         drive(vecs[i].ir, vecs[i].bv, vecs[i].bt, vecs[i].dv, vecs[i].dw, vecs[i].da, vecs[i].dd);
         #1;
         chk($sformatf("c%0d_addr", i), mem_address, vecs[i].addr);
         chk($sformatf("c%0d_we", i), {7'd0, mem_write_enable}, {7'd0, vecs[i].we});
         chk($sformatf("c%0d_wdata", i), mem_write_data, vecs[i].wd);
         chk($sformatf("c%0d_ivalid", i), {7'd0, instr_valid}, {7'd0, vecs[i].iv});
         chk($sformatf("c%0d_idata", i), instr_data, vecs[i].id);
         chk($sformatf("c%0d_ipc", i), instr_pc, vecs[i].ipc);
         chk($sformatf("c%0d_dready", i), {7'd0, dreq_ready}, {7'd0, vecs[i].rdy});
         chk($sformatf("c%0d_drsp_valid", i), {7'd0, drsp_valid}, {7'd0, vecs[i].rv});
         chk($sformatf("c%0d_drsp_data", i), drsp_data, vecs[i].rd);
         chk($sformatf("c%0d_halted", i), {7'd0, halted}, {7'd0, vecs[i].h});
         @(negedge clk);
      end

      // branch to FF with a same-cycle consume, then wrap to 00
      drive(1, 1, 8'hFF, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
      #1;
      chk("br_ff_cleared", {7'd0, instr_valid}, 8'h00);
      wait_iv("fetch_ff");
      chk("fetch_ff_pc", instr_pc, 8'hFF);
      chk("fetch_ff_data", instr_data, 8'hC3);
      chk("wrap_addr", mem_address, 8'h00);
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      #1;
      wait_iv("fetch_00");
      chk("fetch_00_pc", instr_pc, 8'h00);
      chk("fetch_00_data", instr_data, 8'h61);

      // reset during D_ACC of a load abandons it
      chk("ld_ready", {7'd0, dreq_ready}, 8'h01);
      drive(0, 0, 8'h00, 1, 0, 8'h80, 8'h00);
      @(negedge clk);
      dreq_valid = 1'b0;
      #1;
      chk("ld_dacc_addr", mem_address, 8'h80);
      chk("ld_dacc_we", {7'd0, mem_write_enable}, 8'h00);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst2_drsp", {7'd0, drsp_valid}, 8'h00);
      chk("rst2_iv", {7'd0, instr_valid}, 8'h00);
      chk("rst2_addr", mem_address, 8'h00);
      chk("rst2_ready", {7'd0, dreq_ready}, 8'h01);
      chk("rst2_ipc", instr_pc, 8'h00);
      chk("rst2_idata", instr_data, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rst2_no_drsp%0d", i), {7'd0, drsp_valid}, 8'h00);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
